storage_request_scheduler: RTL and testbench
============================================

// Module: storage_request_scheduler
// PURPOSE
// - Queues save/fetch requests (debounced key pulses + 7-slot location) and issues them one at a time to the motion sequencer.
// - Replaces single-entry "temporary key" latching: requests arriving while the mechanism is busy are buffered in order, not lost.
// - Checks each request against a slot-occupancy table and rejects invalid requests.
// - Watches the sequencer handshake with timeouts; a stalled mechanism latches a fault.
// PARAMETERS
// - FIFO_DEPTH    4            request queue depth; power of 2, >=2
// - START_TMO     24_000       clk cycles allowed from command issue to occupy_en high (1 ms @24 MHz)
// - RUN_TMO       480_000_000  clk cycles allowed from occupy_en high to accomplish_en (20 s @24 MHz)
// PORTS
// - clk            in   1  system clock, 24 MHz
// - rst_n          in   1  asynchronous active-low reset
// - save_req       in   1  1-cycle pulse: store request (debounced key1)
// - fetch_req      in   1  1-cycle pulse: retrieve request (debounced key2)
// - location       in   7  one-hot target slot, sampled with the request pulse
// - occupy_en      in   1  sequencer busy
// - accomplish_en  in   1  sequencer done, 1-cycle pulse
// - clear_fault    in   1  1-cycle pulse: leave FAULT
// - cmd_save_en    out  1  store command to sequencer, level
// - cmd_fetch_en   out  1  fetch command to sequencer, level
// - cmd_location   out  7  slot for active command; 0 when idle
// - done_pulse     out  1  1 cycle after a completed command
// - reject_pulse   out  1  1 cycle when a popped request is refused
// - reject_code    out  2  held until next reject: 0 none, 1 location not one-hot, 2 save to occupied slot, 3 fetch from empty slot
// - drop_pulse     out  1  request lost (FIFO full, or fetch colliding with save)
// - occupancy      out  7  bit i = slot i holds an item
// - queue_count    out  clog2(FIFO_DEPTH)+1  entries waiting
// - fault          out  1  timeout latched
// BEHAVIOUR
// - Reset: all outputs 0; FIFO empty; occupancy 0; FSM in IDLE; timers 0. Reset mid-command drops the command immediately; cmd_* go 0 asynchronously.
// - Enqueue: a request writes {op, location} to the FIFO in the same cycle. save_req and fetch_req in the same cycle: save is enqueued, fetch dropped, drop_pulse=1.
// - Full FIFO: the push is dropped and drop_pulse=1, unless a pop occurs in the same cycle; then the push is accepted.
// - FSM states: IDLE, CHECK, WAIT_START, RUN, DONE, FAULT.
//   - IDLE: FIFO not empty -> pop head into a command register -> CHECK (next cycle).
//   - CHECK, 1 cycle:
//     - Invalid location (0 or multi-hot): code 1.
//     - Save to an occupied slot: code 2.
//     - Fetch from an empty slot: code 3.
//     - Any rejection: reject_pulse=1, reject_code updated, -> IDLE.
//     - Otherwise: assert cmd_save_en or cmd_fetch_en, drive cmd_location, -> WAIT_START.
//     - Minimum latency from request into an empty idle FIFO to command asserted: 3 cycles.
//   - WAIT_START: occupy_en=1 -> RUN, timer cleared. Timer reaching START_TMO -> FAULT.
//   - RUN: cmd_* stays asserted until accomplish_en.
//     - On accomplish_en: save sets the occupancy bit, fetch clears it. Deassert cmd_*, cmd_location=0, -> DONE.
//     - Timer reaching RUN_TMO -> FAULT.
//     - accomplish_en in any other state is ignored.
//   - DONE: done_pulse=1 for 1 cycle -> IDLE.
//   - FAULT: cmd_* = 0, fault=1, occupancy frozen. The FIFO keeps accepting requests up to full.
//     - clear_fault -> IDLE, fault=0. The failed command is discarded and never retried.
// - Occupancy is checked at pop time, not enqueue time: two queued saves to the same slot give one success and one code-2 reject.
// - Timers: 32-bit, count only in WAIT_START/RUN, cleared on every state entry.
// STRUCTURE
// - Package storage_pkg: NSLOT=7, state encoding, reject codes, op encoding (0 save, 1 fetch), onehot7 check function.
// - Sub-module sched_req_fifo (FIFO_DEPTH x 8 bits {op, loc}), synchronous push/pop, count output, simultaneous push/pop when full allowed.
// - Top: FSM, command register, occupancy register, timeout counter.
// TESTING
// - Save slot 0x04 into an idle block -> cmd_save_en high 3 cycles later with cmd_location=0x04. Drive occupy_en; then accomplish_en -> occupancy=0x04, done_pulse once.
// - During RUN, send save 0x01, fetch 0x04, save 0x02 -> queue_count=3; executed in order; final occupancy=0x03.
// - Fetch 0x08 with occupancy=0 -> reject_pulse, reject_code=3, no cmd_* assertion. location=0x05 -> reject_code=1.
// - Fill the FIFO (4) while busy, then a 5th request -> drop_pulse, queue_count stays 4. Simultaneous save/fetch -> save kept, drop_pulse.
// - Never raise occupy_en -> fault=1 at START_TMO (override to 100 in sim), cmd_* = 0. Then clear_fault -> next queued command issues.
// - Assert rst_n=0 during RUN -> cmd_* = 0 at once, occupancy=0, queue_count=0.

Source files
------------

// File: rtl/storage_pkg.sv
// storage_pkg: shared types for the storage request scheduler.
// Holds the slot count, FSM state encoding, reject codes, request op encoding,
// the queued request record {op, loc}, and a one-hot check on a 7-bit location.
package storage_pkg;

    localparam int NSLOT = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_WAIT_START,
        S_RUN,
        S_DONE,
        S_FAULT
    } state_e;

    typedef enum logic [1:0] {
        REJ_NONE  = 2'd0,
        REJ_LOC   = 2'd1,
        REJ_OCC   = 2'd2,
        REJ_EMPTY = 2'd3
    } rej_e;

    localparam logic OP_SAVE  = 1'b0;
    localparam logic OP_FETCH = 1'b1;

    typedef struct packed {
        logic             op;
        logic [NSLOT-1:0] loc;
    } req_t;

    // True when exactly one bit of the location is set.
    function automatic logic onehot7(input logic [NSLOT-1:0] v);
        return (v != '0) && ((v & (v - 7'd1)) == '0);
    endfunction

endpackage

// File: rtl/sched_req_fifo.sv
// sched_req_fifo: request queue feeding the scheduler FSM.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push_i       write data_i this cycle
//   pop_i        consume the head this cycle (ignored when empty)
//   data_i       entry to write
//   data_o       current head entry
//   count_o      entries held
//   full_o       count_o == DEPTH
//   empty_o      count_o == 0
// A push into a full queue is accepted when a pop happens in the same cycle.
module sched_req_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  data_i,
    output logic [W-1:0]  data_o,
    output logic [AW:0]   count_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign do_pop  = pop_i && (cnt_q != '0);
    assign do_push = push_i && ((cnt_q != CNT_FULL) || do_pop);

    always_ff @(posedge clk)
        if (do_push) mem_q[wr_q] <= data_i;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end

    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;
    assign full_o  = cnt_q == CNT_FULL;
    assign empty_o = cnt_q == '0;

endmodule

// File: rtl/storage_request_scheduler.sv
// storage_request_scheduler: queues save/fetch key requests and issues them one
// at a time to the motion sequencer, rejecting invalid ones and latching a fault
// when the sequencer handshake stalls.
// Ports:
//   clk, rst_n          24 MHz clock, asynchronous active-low reset
//   save_req_i          1-cycle store request pulse
//   fetch_req_i         1-cycle retrieve request pulse
//   location_i          one-hot target slot, sampled with the request
//   occupy_en_i         sequencer busy
//   accomplish_en_i     sequencer done pulse
//   clear_fault_i       leave FAULT
//   cmd_save_en_o       store command level
//   cmd_fetch_en_o      fetch command level
//   cmd_location_o      slot of the active command, 0 when idle
//   done_pulse_o        1 cycle after a completed command
//   reject_pulse_o      1 cycle when a popped request is refused
//   reject_code_o       last reject reason, held
//   drop_pulse_o        1 cycle when a request was lost
//   occupancy_o         bit i = slot i holds an item
//   queue_count_o       requests waiting
//   fault_o             handshake timeout latched
module storage_request_scheduler
    import storage_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter int unsigned START_TMO  = 24_000,
    parameter int unsigned RUN_TMO    = 480_000_000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         save_req_i,
    input  logic                         fetch_req_i,
    input  logic [NSLOT-1:0]             location_i,
    input  logic                         occupy_en_i,
    input  logic                         accomplish_en_i,
    input  logic                         clear_fault_i,
    output logic                         cmd_save_en_o,
    output logic                         cmd_fetch_en_o,
    output logic [NSLOT-1:0]             cmd_location_o,
    output logic                         done_pulse_o,
    output logic                         reject_pulse_o,
    output logic [1:0]                   reject_code_o,
    output logic                         drop_pulse_o,
    output logic [NSLOT-1:0]             occupancy_o,
    output logic [$clog2(FIFO_DEPTH):0]  queue_count_o,
    output logic                         fault_o
);

    // Last cycle index the timer may reach in a state before timing out.
    localparam logic [31:0] START_LIM = START_TMO - 1;
    localparam logic [31:0] RUN_LIM   = RUN_TMO - 1;

    state_e           state_q, state_d;
    req_t             cmd_q, cmd_d;
    logic [NSLOT-1:0] occ_q, occ_d;
    logic [31:0]      tmr_q, tmr_d;
    logic             rej_pulse_q, rej_pulse_d;
    logic [1:0]       rej_code_q, rej_code_d;
    logic             drop_q, drop_d;
    rej_e             rej_c;
    req_t             push_req, head;
    logic             push, pop, full, empty, cmd_active;

    // Simultaneous save and fetch keep the save; the fetch is counted as a drop.
    assign push     = save_req_i | fetch_req_i;
    assign push_req = '{op: save_req_i ? OP_SAVE : OP_FETCH, loc: location_i};
    assign pop      = (state_q == S_IDLE) && !empty;
    assign drop_d   = (save_req_i & fetch_req_i) | (push & full & ~pop);

    sched_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(req_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (push_req),
        .data_o  (head),
        .count_o (queue_count_o),
        .full_o  (full),
        .empty_o (empty)
    );

    // Occupancy is judged when the request reaches CHECK, not when it was queued.
    assign rej_c = !onehot7(cmd_q.loc)                                   ? REJ_LOC   :
                   (cmd_q.op == OP_SAVE) && ((occ_q & cmd_q.loc) != '0)  ? REJ_OCC   :
                   (cmd_q.op == OP_FETCH) && ((occ_q & cmd_q.loc) == '0) ? REJ_EMPTY :
                                                                          REJ_NONE;

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        occ_d       = occ_q;
        rej_pulse_d = 1'b0;
        rej_code_d  = rej_code_q;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    cmd_d   = head;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (rej_c != REJ_NONE) begin
                    rej_pulse_d = 1'b1;
                    rej_code_d  = rej_c;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_WAIT_START;
                end
            end
            S_WAIT_START: begin
                if (occupy_en_i) state_d = S_RUN;
                else if (tmr_q >= START_LIM) state_d = S_FAULT;
            end
            S_RUN: begin
                if (accomplish_en_i) begin
                    occ_d   = (cmd_q.op == OP_SAVE) ? (occ_q | cmd_q.loc) : (occ_q & ~cmd_q.loc);
                    state_d = S_DONE;
                end else if (tmr_q >= RUN_LIM) begin
                    state_d = S_FAULT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_FAULT: if (clear_fault_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Timer restarts on every state change and only runs while waiting on the sequencer.
        tmr_d = (state_d != state_q) ? '0 :
                ((state_q == S_WAIT_START) || (state_q == S_RUN)) ? tmr_q + 32'd1 : '0;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            occ_q       <= '0;
            tmr_q       <= '0;
            rej_pulse_q <= 1'b0;
            rej_code_q  <= 2'd0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            occ_q       <= occ_d;
            tmr_q       <= tmr_d;
            rej_pulse_q <= rej_pulse_d;
            rej_code_q  <= rej_code_d;
            drop_q      <= drop_d;
        end

    // Command outputs decode straight from the state so reset clears them at once.
    assign cmd_active     = (state_q == S_WAIT_START) || (state_q == S_RUN);
    assign cmd_save_en_o  = cmd_active && (cmd_q.op == OP_SAVE);
    assign cmd_fetch_en_o = cmd_active && (cmd_q.op == OP_FETCH);
    assign cmd_location_o = cmd_active ? cmd_q.loc : '0;
    assign done_pulse_o   = state_q == S_DONE;
    assign fault_o        = state_q == S_FAULT;
    assign reject_pulse_o = rej_pulse_q;
    assign reject_code_o  = rej_code_q;
    assign drop_pulse_o   = drop_q;
    assign occupancy_o    = occ_q;

endmodule

// File: tb/tb_storage_request_scheduler.sv
// tb_storage_request_scheduler: directed and randomized checks of the scheduler
// against an in-order transaction model of queued requests and slot occupancy.
module tb_storage_request_scheduler;

    localparam int DEPTH = 4;
    localparam int STMO  = 100;
    localparam int RTMO  = 1000;

    typedef struct {
        bit         rej;
        logic [1:0] code;
        bit         op;
        logic [6:0] loc;
        logic [6:0] occ_after;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       save_i = 1'b0, fetch_i = 1'b0, clr_i = 1'b0;
    logic [6:0] loc_i = '0;
    logic       occ_r = 1'b0, acc_r = 1'b0, occ_m = 1'b0, acc_m = 1'b0;
    logic       cmd_save_o, cmd_fetch_o, done_pulse_o, reject_pulse_o, drop_pulse_o, fault_o;
    logic [6:0] cmd_location_o, occupancy_o;
    logic [1:0] reject_code_o;
    logic [2:0] queue_count_o;

    int         n_cmp = 0, n_bad = 0;
    ev_t        exp_q[$];
    ev_t        e;
    logic [6:0] m_occ = '0, pend_occ = '0;
    int         submitted = 0, resolved = 0;
    bit         resp_en = 0;
    int         dly_max = 3, run_max = 5;
    logic       prev_cmd = 1'b0;

    always #5 clk = ~clk;

    storage_request_scheduler #(
        .FIFO_DEPTH (DEPTH),
        .START_TMO  (STMO),
        .RUN_TMO    (RTMO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .save_req_i      (save_i),
        .fetch_req_i     (fetch_i),
        .location_i      (loc_i),
        .occupy_en_i     (occ_r | occ_m),
        .accomplish_en_i (acc_r | acc_m),
        .clear_fault_i   (clr_i),
        .cmd_save_en_o   (cmd_save_o),
        .cmd_fetch_en_o  (cmd_fetch_o),
        .cmd_location_o  (cmd_location_o),
        .done_pulse_o    (done_pulse_o),
        .reject_pulse_o  (reject_pulse_o),
        .reject_code_o   (reject_code_o),
        .drop_pulse_o    (drop_pulse_o),
        .occupancy_o     (occupancy_o),
        .queue_count_o   (queue_count_o),
        .fault_o         (fault_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one request; the model decides its fate in queue order.
    task automatic send(input bit s, input bit f, input logic [6:0] loc, input bit exp_drop);
        ev_t ne;
        bit  op;
        @(posedge clk); #1;
        save_i = s; fetch_i = f; loc_i = loc;
        if (!exp_drop) begin
            op = !s;
            submitted++;
            ne.op = op; ne.loc = loc; ne.rej = 1; ne.code = 0; ne.occ_after = m_occ;
            if ($countones(loc) != 1) ne.code = 1;
            else if (!op && (m_occ & loc) != 0) ne.code = 2;
            else if (op && (m_occ & loc) == 0) ne.code = 3;
            else begin
                ne.rej = 0;
                m_occ = op ? (m_occ & ~loc) : (m_occ | loc);
                ne.occ_after = m_occ;
            end
            exp_q.push_back(ne);
        end
        @(posedge clk); #1;
        save_i = 0; fetch_i = 0; loc_i = 0;
        @(negedge clk);
        chk("drop_pulse", drop_pulse_o, exp_drop || (s && f));
    endtask

    task automatic wait_cmd();
        int i;
        for (i = 0; i < 50 && !(cmd_save_o || cmd_fetch_o); i++) @(negedge clk);
        chk("cmd_issued", cmd_save_o || cmd_fetch_o, 1);
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && queue_count_o == 0 && !cmd_save_o && !cmd_fetch_o && !done_pulse_o) break;
        end
        chk("drain_done", i < 20000, 1);
        repeat (4) @(negedge clk);
    endtask

    // Scoreboard: every reject or command start must match the next modelled outcome.
    always @(negedge clk) begin
        if (!rst_n) prev_cmd = 1'b0;
        else begin
            if (reject_pulse_o) begin
                chk("rej_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    resolved++;
                    chk("rej_kind", e.rej, 1);
                    chk("rej_code", reject_code_o, e.code);
                end
            end
            if ((cmd_save_o || cmd_fetch_o) && !prev_cmd) begin
                chk("cmd_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    resolved++;
                    chk("cmd_kind", e.rej, 0);
                    chk("cmd_fetch", cmd_fetch_o, e.op);
                    chk("cmd_save", cmd_save_o, !e.op);
                    chk("cmd_loc", cmd_location_o, e.loc);
                    pend_occ = e.occ_after;
                end
            end
            if (done_pulse_o) chk("done_occ", occupancy_o, pend_occ);
            prev_cmd = cmd_save_o || cmd_fetch_o;
        end
    end

    // Sequencer model: raises occupy_en after a delay, then pulses accomplish_en.
    initial forever begin
        @(posedge clk); #1;
        if (resp_en && rst_n && (cmd_save_o || cmd_fetch_o)) begin
            repeat ($urandom_range(dly_max, 0)) @(posedge clk);
            #1 occ_r = 1;
            repeat ($urandom_range(run_max, 1)) @(posedge clk);
            #1 acc_r = 1;
            @(posedge clk);
            #1 acc_r = 0; occ_r = 0;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         s;
        logic [6:0] l;
        #1 rst_n = 0;
        #1;
        chk("rst_ctl", {cmd_save_o, cmd_fetch_o, done_pulse_o, reject_pulse_o, drop_pulse_o, fault_o}, 0);
        chk("rst_data", {reject_code_o, cmd_location_o, occupancy_o, queue_count_o}, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        // First command latency and RUN-time queueing.
        send(1, 0, 7'h04, 0);
        chk("q_after_push", queue_count_o, 1);
        chk("cmd_c1", cmd_save_o, 0);
        @(negedge clk);
        chk("cmd_c2", cmd_save_o, 0);
        @(negedge clk);
        chk("cmd_save_c3", cmd_save_o, 1);
        chk("cmd_loc_c3", cmd_location_o, 7'h04);
        @(posedge clk); #1 occ_m = 1;
        send(1, 0, 7'h01, 0);
        send(0, 1, 7'h04, 0);
        send(1, 0, 7'h02, 0);
        chk("q_three", queue_count_o, 3);
        chk("still_run", cmd_save_o, 1);
        @(posedge clk); #1 acc_m = 1;
        @(negedge clk);
        chk("no_done_yet", done_pulse_o, 0);
        @(posedge clk); #1 acc_m = 0; occ_m = 0;
        @(negedge clk);
        chk("occ_t1", occupancy_o, 7'h04);
        chk("done_t1", done_pulse_o, 1);
        chk("cmd_off_t1", {cmd_save_o, cmd_fetch_o, cmd_location_o}, 0);
        @(negedge clk);
        chk("done_once", done_pulse_o, 0);
        resp_en = 1;
        drain();
        chk("occ_t2", occupancy_o, 7'h03);
        // Rejections.
        send(0, 1, 7'h08, 0);
        @(negedge clk);
        chk("rej_not_yet", reject_pulse_o, 0);
        @(negedge clk);
        chk("rej3_pulse", reject_pulse_o, 1);
        chk("rej3_code", reject_code_o, 3);
        chk("rej3_nocmd", cmd_save_o || cmd_fetch_o, 0);
        send(1, 0, 7'h05, 0);
        drain();
        chk("rej1_code", reject_code_o, 1);
        send(1, 0, 7'h01, 0);
        drain();
        chk("rej2_code", reject_code_o, 2);
        // Start timeout, fault hold, and recovery.
        resp_en = 0;
        send(1, 0, 7'h10, 0);
        wait_cmd();
        repeat (STMO - 1) @(negedge clk);
        chk("pre_tmo_fault", fault_o, 0);
        chk("pre_tmo_cmd", cmd_save_o, 1);
        @(negedge clk);
        chk("tmo_fault", fault_o, 1);
        chk("tmo_cmd_off", {cmd_save_o, cmd_fetch_o, cmd_location_o}, 0);
        m_occ = m_occ & ~7'h10;
        send(0, 1, 7'h01, 0);
        chk("fault_queue", queue_count_o, 1);
        repeat (5) @(negedge clk);
        chk("fault_hold", fault_o, 1);
        chk("fault_occ_frozen", occupancy_o, 7'h03);
        resp_en = 1;
        @(posedge clk); #1 clr_i = 1;
        @(posedge clk); #1 clr_i = 0;
        @(negedge clk);
        chk("fault_cleared", fault_o, 0);
        drain();
        chk("occ_t5", occupancy_o, 7'h02);
        // Full queue, simultaneous requests, reset during RUN.
        resp_en = 0;
        send(1, 0, 7'h20, 0);
        wait_cmd();
        @(posedge clk); #1 occ_m = 1;
        send(1, 0, 7'h40, 0);
        send(0, 1, 7'h02, 0);
        send(1, 0, 7'h08, 0);
        send(1, 1, 7'h01, 0);
        chk("q_full", queue_count_o, 4);
        send(1, 0, 7'h04, 1);
        chk("q_stays_full", queue_count_o, 4);
        @(negedge clk);
        chk("pre_rst_cmd", cmd_save_o, 1);
        chk("pre_rst_occ", occupancy_o, 7'h02);
        rst_n = 0;
        #1;
        chk("rst_cmd", {cmd_save_o, cmd_fetch_o, cmd_location_o}, 0);
        chk("rst_occ", occupancy_o, 0);
        chk("rst_q", queue_count_o, 0);
        occ_m = 0; exp_q.delete(); m_occ = 0; submitted = 0; resolved = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        // Randomized traffic against the model.
        resp_en = 1; dly_max = 20; run_max = 20;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 250; k++) begin
            if ($urandom_range(2, 0) == 0 && (submitted - resolved) < DEPTH) begin
                s = 1'($urandom_range(1, 0));
                l = ($urandom_range(9, 0) < 7) ? 7'(1 << $urandom_range(6, 0)) : 7'($urandom_range(127, 0));
                send(s, !s, l, 0);
            end else begin
                @(negedge clk);
            end
        end
        drain();
        chk("rnd_occ", occupancy_o, m_occ);
        chk("rnd_q", queue_count_o, 0);
        chk("rnd_fault", fault_o, 0);
        chk("rnd_pending", exp_q.size(), 0);
        chk("idle_loc", cmd_location_o, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
